// File: rtl/stream_pkg.sv
// Shared types and defaults for the valid/ready byte-stream transmitter.
package stream_pkg;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, DRIVE, STALL} tx_state_t;
endpackage

// File: rtl/stream_tx_fifo.sv
// Synchronous FIFO. The pointers carry an extra wrap bit so that full and empty
// can be told apart without a separate counter.
module stream_tx_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; it is only read behind a valid pointer pair.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/stream_tx.sv
// Stream initiator: buffers producer words, presents them on valid_o/data_o
// under ready_i back-pressure, counts transfers and watches for a stuck sink.
module stream_tx
  import stream_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64,
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic [LW-1:0]     level_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  tx_count_o,
  output logic              timeout_o,
  input  logic              clr_timeout_i
);
  localparam int AW = $clog2(DEPTH);
  // Wide enough to hold TIMEOUT_CYC, and never zero bits when the watchdog is off.
  localparam int SW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [SW-1:0] TO = SW'(TIMEOUT_CYC);

  tx_state_t         state, state_nxt;
  logic              push, pop, xfer, empty, stall, to_set;
  logic [DATA_W-1:0] head;
  logic [AW:0]       lvl;
  logic [SW-1:0]     stall_cnt;

  assign push    = wr_en_i && !full_o;
  assign valid_o = (state != IDLE);
  assign xfer    = valid_o && ready_i;
  assign pop     = !empty && ((state == IDLE) || xfer);
  assign stall   = valid_o && !ready_i;
  assign to_set  = (TIMEOUT_CYC != 0) && stall && (stall_cnt == TO - 1'b1);
  assign level_o = LW'(lvl);

  stream_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_data_i),
    .pop     (pop),
    .rd_data (head),
    .full    (full_o),
    .empty   (empty),
    .level   (lvl)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = DRIVE;
      DRIVE: begin
        if (xfer)        state_nxt = empty ? IDLE : DRIVE;
        else if (to_set) state_nxt = STALL;
      end
      STALL: begin
        if (xfer)               state_nxt = empty ? IDLE : DRIVE;
        else if (clr_timeout_i) state_nxt = DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_o     <= '0;
      tx_count_o <= '0;
      stall_cnt  <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop)  data_o     <= head;
      if (xfer) tx_count_o <= tx_count_o + 1'b1;

      // A timeout firing in the same cycle as a clear takes precedence.
      if (xfer)                                stall_cnt <= '0;
      else if (to_set)                         stall_cnt <= TO;
      else if (clr_timeout_i)                  stall_cnt <= '0;
      else if (stall && (stall_cnt < TO))      stall_cnt <= stall_cnt + 1'b1;

      if (to_set)             timeout_o <= 1'b1;
      else if (clr_timeout_i) timeout_o <= 1'b0;
    end
  end
endmodule
